// File: rtl/trdb_reg_master.sv
// -----------------------------------------------------------------------------
// trdb_reg_master
//   Initiator for the trace debugger's peripheral register bus. Register
//   commands arrive on a valid/ready command port and are queued in a small
//   FIFO. They are issued one at a time, in order, on the per_* bus. Every
//   command, read or write, returns exactly one response on a valid/ready
//   response port.
//
// Optional feature (compile-time macro TRDB_MASTER_TIMEOUT_EN):
//   Aborts a bus request after TIMEOUT_CYCLES cycles without per_ready_i and
//   returns a response with rsp_err_o = 1. Without the macro, REQ waits
//   indefinitely and rsp_err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   cmd_valid_i/ready_o    command handshake (we, addr, wdata)
//   rsp_valid_o/ready_i    response handshake (rdata, we echo, err)
//   per_valid_o..wdata_o   bus request
//   per_rdata_i, ready_i   bus completion
//   busy_o                 FIFO non-empty or a command in flight
//
// FSM states:
//   state  | meaning
//   IDLE   | waiting for a queued command; pops the FIFO head into per_* regs
//   REQ    | per_valid_o high, waiting for per_ready_i (or timeout)
//   RSP    | rsp_valid_o high, waiting for rsp_ready_i
// -----------------------------------------------------------------------------
module trdb_reg_master #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int CMD_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [31:0]               cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [31:0]               rsp_rdata_o,
    output logic                      rsp_we_o,
    output logic                      rsp_err_o,
    output logic                      per_valid_o,
    output logic                      per_we_o,
    output logic [APB_ADDR_WIDTH-1:0] per_addr_o,
    output logic [31:0]               per_wdata_o,
    input  logic [31:0]               per_rdata_i,
    input  logic                      per_ready_i,
    output logic                      busy_o
);

    localparam int PW = $clog2(CMD_DEPTH);
    localparam int CW = PW + 1;

    if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("trdb_reg_master: CMD_DEPTH must be a power of two >= 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("trdb_reg_master: TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic                      r_mem_we    [CMD_DEPTH];
    logic [APB_ADDR_WIDTH-1:0] r_mem_addr  [CMD_DEPTH];
    logic [31:0]               r_mem_wdata [CMD_DEPTH];

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_cmd_ready;
    logic [CW-1:0] w_count_nxt;
    logic          w_push;
    logic          w_pop;

    state_t        r_state;

    assign w_push = cmd_valid_i & r_cmd_ready;
    // The FSM only pops from IDLE, so a newly pushed entry is seen one cycle
    // after its push and never bypasses the storage.
    assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_we[r_wr_ptr]    <= cmd_we_i;
            r_mem_addr[r_wr_ptr]  <= cmd_addr_i;
            r_mem_wdata[r_wr_ptr] <= cmd_wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt != CW'(CMD_DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // Bus / response FSM
    // ------------------------------------------------------------------
    logic                      r_per_valid;
    logic                      r_per_we;
    logic [APB_ADDR_WIDTH-1:0] r_per_addr;
    logic [31:0]               r_per_wdata;
    logic                      r_rsp_valid;
    logic                      r_rsp_we;
    logic [31:0]               r_rsp_rdata;

`ifdef TRDB_MASTER_TIMEOUT_EN
    localparam int TW_RAW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TW     = (TW_RAW < 8) ? 8 : ((TW_RAW > 32) ? 32 : TW_RAW);

    logic          r_rsp_err;
    logic [TW-1:0] r_tmo_cnt;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_per_valid <= 1'b0;
            r_per_we    <= 1'b0;
            r_per_addr  <= '0;
            r_per_wdata <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_we    <= 1'b0;
            r_rsp_rdata <= '0;
`ifdef TRDB_MASTER_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
            r_tmo_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_per_we    <= r_mem_we[r_rd_ptr];
                        r_per_addr  <= r_mem_addr[r_rd_ptr];
                        r_per_wdata <= r_mem_wdata[r_rd_ptr];
                        r_per_valid <= 1'b1;
                        r_state     <= S_REQ;
`ifdef TRDB_MASTER_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                    end
                end
                S_REQ: begin
                    // A completion in the final allowed cycle beats the timeout.
                    if (per_ready_i) begin
                        r_rsp_rdata <= r_per_we ? 32'h0 : per_rdata_i;
                        r_rsp_we    <= r_per_we;
                        r_per_valid <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
`ifdef TRDB_MASTER_TIMEOUT_EN
                        r_rsp_err   <= 1'b0;
`endif
                    end
`ifdef TRDB_MASTER_TIMEOUT_EN
                    else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_rsp_rdata <= 32'h0;
                        r_rsp_we    <= r_per_we;
                        r_rsp_err   <= 1'b1;
                        r_per_valid <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RSP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + TW'(1);
                    end
`endif
                end
                S_RSP: begin
                    if (rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_per_valid <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign per_valid_o = r_per_valid;
    assign per_we_o    = r_per_we;
    assign per_addr_o  = r_per_addr;
    assign per_wdata_o = r_per_wdata;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_we_o    = r_rsp_we;
    assign rsp_rdata_o = r_rsp_rdata;
    assign busy_o      = (r_count != '0) || (r_state != S_IDLE);

`ifdef TRDB_MASTER_TIMEOUT_EN
    assign rsp_err_o = r_rsp_err;
`else
    assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_trdb_reg_master.sv
// -----------------------------------------------------------------------------
// tb_trdb_reg_master
//   Directed bench for trdb_reg_master. A transaction-level model (queues of
//   accepted commands and expected responses) is checked against the DUT on
//   every falling edge; directed sequences add literal cycle-exact checks.
// -----------------------------------------------------------------------------
module tb_trdb_reg_master;

    localparam int AW    = 12;
    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_we;
    logic          rsp_err;
    logic          per_valid;
    logic          per_we;
    logic [AW-1:0] per_addr;
    logic [31:0]   per_wdata;
    logic [31:0]   per_rdata;
    logic          per_ready;
    logic          busy;

    always #5 clk = ~clk;

    trdb_reg_master #(
        .APB_ADDR_WIDTH (AW),
        .CMD_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_addr_i  (cmd_addr),
        .cmd_wdata_i (cmd_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_rdata_o (rsp_rdata),
        .rsp_we_o    (rsp_we),
        .rsp_err_o   (rsp_err),
        .per_valid_o (per_valid),
        .per_we_o    (per_we),
        .per_addr_o  (per_addr),
        .per_wdata_o (per_wdata),
        .per_rdata_i (per_rdata),
        .per_ready_i (per_ready),
        .busy_o      (busy)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Transaction model
    // ------------------------------------------------------------------
    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [31:0]   wdata;
    } cmd_t;

    typedef struct {
        logic        we;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    cmd_t cmd_q[$];    // accepted, bus transfer not yet finished
    rsp_t rsp_q[$];    // bus transfer finished, response not yet consumed
    int   wait_cnt   = 0;
    int   n_rsp_done = 0;

    always @(negedge clk) begin
        int   outstanding;
        logic rsp_pending;
        if (rst) begin
            cmd_q.delete();
            rsp_q.delete();
            wait_cnt = 0;
            chk("rst_per_valid", per_valid, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
        end else begin
            outstanding = cmd_q.size() + rsp_q.size();
            rsp_pending = (rsp_q.size() != 0);
            chk("busy", busy, outstanding != 0);
            if (outstanding < DEPTH)
                chk("cmd_ready_room", cmd_ready, 1);
            else if (outstanding > DEPTH)
                chk("cmd_ready_full", cmd_ready, 0);

            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", rsp_valid, 0);
                end else begin
                    chk("rsp_we", rsp_we, rsp_q[0].we);
                    chk("rsp_rdata", rsp_rdata, rsp_q[0].rdata);
                    chk("rsp_err", rsp_err, rsp_q[0].err);
                    if (rsp_ready) begin
                        void'(rsp_q.pop_front());
                        n_rsp_done++;
                    end
                end
            end

            if (per_valid) begin
                if (rsp_pending)
                    chk("req_while_rsp_pending", per_valid, 0);
                if (cmd_q.size() == 0) begin
                    chk("stale_req", per_valid, 0);
                end else begin
                    chk("per_we", per_we, cmd_q[0].we);
                    chk("per_addr", per_addr, cmd_q[0].addr);
                    chk("per_wdata", per_wdata, cmd_q[0].wdata);
                    if (per_ready) begin
                        rsp_q.push_back('{cmd_q[0].we, cmd_q[0].we ? 32'h0 : per_rdata, 1'b0});
                        void'(cmd_q.pop_front());
                        wait_cnt = 0;
                    end
`ifdef TRDB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == TMO - 1) begin
                        rsp_q.push_back('{cmd_q[0].we, 32'h0, 1'b1});
                        void'(cmd_q.pop_front());
                        wait_cnt = 0;
                    end
`endif
                    else begin
                        wait_cnt++;
                    end
                end
            end

            if (cmd_valid && cmd_ready)
                cmd_q.push_back('{cmd_we, cmd_addr, cmd_wdata});
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = addr;
        cmd_wdata = wdata;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 300) begin
            step();
            k++;
        end
        chk(name, busy, 0);
    endtask

    initial begin
        int base;
        int cnt;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        per_ready = 1'b1;
        per_rdata = 32'hFFFF_FFFF;

        // Reset values
        step();
        step();
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_per_valid", per_valid, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_we", rsp_we, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_per_we", per_we, 0);
        chk("reset_per_addr", per_addr, 0);
        chk("reset_per_wdata", per_wdata, 0);
        rst = 1'b0;
        step();

        // Write, minimum latency
        step();
        offer(1'b1, 12'h000, 32'h0000_0001);                       // cycle 0
        chk("t1_c0_ready", cmd_ready, 1);
        step(); cmd_valid = 1'b0;                                  // cycle 1
        chk("t1_c1_per_valid", per_valid, 0);
        chk("t1_c1_busy", busy, 1);
        step();                                                    // cycle 2
        chk("t1_c2_per_valid", per_valid, 1);
        chk("t1_c2_per_we", per_we, 1);
        chk("t1_c2_per_addr", per_addr, 12'h000);
        chk("t1_c2_per_wdata", per_wdata, 32'h1);
        step();                                                    // cycle 3
        chk("t1_c3_per_valid", per_valid, 0);
        chk("t1_c3_rsp_valid", rsp_valid, 1);
        chk("t1_c3_rsp_we", rsp_we, 1);
        chk("t1_c3_rsp_rdata", rsp_rdata, 0);
        step();                                                    // cycle 4
        chk("t1_c4_rsp_valid", rsp_valid, 0);
        chk("t1_c4_busy", busy, 0);

        // Stalled read
        per_ready = 1'b0;
        per_rdata = 32'h0;
        step(); offer(1'b0, 12'h004, 32'h55AA_55AA);               // cycle 0
        step(); cmd_valid = 1'b0;                                  // cycle 1
        for (int i = 0; i < 3; i++) begin                          // cycles 2..4
            step();
            chk("t2_stall_valid", per_valid, 1);
            chk("t2_stall_addr", per_addr, 12'h004);
            chk("t2_stall_we", per_we, 0);
            chk("t2_stall_wdata", per_wdata, 32'h55AA_55AA);
        end
        step(); per_ready = 1'b1; per_rdata = 32'hDEAD_BEEF;       // cycle 5
        chk("t2_hs_valid", per_valid, 1);
        chk("t2_hs_addr", per_addr, 12'h004);
        step(); per_ready = 1'b0; per_rdata = 32'h0;               // cycle 6
        chk("t2_per_valid_drop", per_valid, 0);
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t2_rsp_we", rsp_we, 0);
        step();
        wait_idle("t2_idle");

        // FIFO full
        per_ready = 1'b1;
        per_rdata = 32'h1000_0000;
        rsp_ready = 1'b0;
        base = n_rsp_done;
        for (int i = 0; i < 6; i++) begin
            step();
            offer(1'(i), AW'(12'h100 + 4 * i), 32'hA0 + 32'(i));
            chk("t3_cmd_ready", cmd_ready, i < 5);
        end
        step(); cmd_valid = 1'b0;
        chk("t3_still_full", cmd_ready, 0);
        step();
        step();
        rsp_ready = 1'b1;
        wait_idle("t3_idle");
        chk("t3_rsp_count", n_rsp_done - base, 5);
        chk("t3_ready_back", cmd_ready, 1);

        // Response backpressure
        rsp_ready = 1'b0;
        per_rdata = 32'h1234_5678;
        step(); offer(1'b0, 12'h200, 32'h0);                       // cycle 0
        step(); offer(1'b1, 12'h204, 32'hB0B0_B0B0);               // cycle 1
        step(); cmd_valid = 1'b0;                                  // cycle 2
        chk("t4_req_a", per_valid, 1);
        chk("t4_req_a_addr", per_addr, 12'h200);
        for (int i = 0; i < 5; i++) begin                          // cycles 3..7
            step();
            chk("t4_bp_rsp_valid", rsp_valid, 1);
            chk("t4_bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
            chk("t4_bp_per_valid", per_valid, 0);
        end
        step(); rsp_ready = 1'b1;                                  // cycle 8
        chk("t4_hs_rsp_valid", rsp_valid, 1);
        step();                                                    // cycle 9
        chk("t4_gap_per_valid", per_valid, 0);
        chk("t4_gap_rsp_valid", rsp_valid, 0);
        step();                                                    // cycle 10
        chk("t4_req_b", per_valid, 1);
        chk("t4_req_b_addr", per_addr, 12'h204);
        step();                                                    // cycle 11
        chk("t4_rsp_b_valid", rsp_valid, 1);
        chk("t4_rsp_b_we", rsp_we, 1);
        chk("t4_rsp_b_rdata", rsp_rdata, 0);
        step();
        wait_idle("t4_idle");

        // Reset mid-request
        per_ready = 1'b0;
        step(); offer(1'b1, 12'h300, 32'h3);                       // cycle 0
        step(); offer(1'b1, 12'h304, 32'h4);                       // cycle 1
        step(); offer(1'b0, 12'h308, 32'h5);                       // cycle 2
        chk("t5_c2_per_valid", per_valid, 1);
        step(); cmd_valid = 1'b0;                                  // cycle 3
        chk("t5_c3_per_valid", per_valid, 1);
        chk("t5_c3_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("t5_async_per_valid", per_valid, 0);
        chk("t5_async_rsp_valid", rsp_valid, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_ready", cmd_ready, 1);
        step();
        step();
        rst = 1'b0;
        per_ready = 1'b1;
        chk("t5_rel_busy", busy, 0);
        chk("t5_rel_ready", cmd_ready, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_no_stale_req", per_valid, 0);
        end

`ifdef TRDB_MASTER_TIMEOUT_EN
        // Timeout: no completion at all
        per_ready = 1'b0;
        per_rdata = 32'h7777_7777;
        step(); offer(1'b0, 12'h3F0, 32'h0);                       // cycle 0
        step(); cmd_valid = 1'b0;                                  // cycle 1
        step();                                                    // cycle 2
        cnt = 0;
        for (int k = 0; k < 40 && per_valid; k++) begin
            cnt++;
            step();
        end
        chk("t6_valid_len", cnt, TMO);
        chk("t6_rsp_valid", rsp_valid, 1);
        chk("t6_rsp_err", rsp_err, 1);
        chk("t6_rsp_rdata", rsp_rdata, 0);
        step();
        wait_idle("t6_idle");

        // Timeout: completion in the final allowed cycle wins
        step(); offer(1'b0, 12'h3F4, 32'h0);                       // cycle 0
        step(); cmd_valid = 1'b0;                                  // cycle 1
        for (int k = 0; k < TMO - 1; k++) begin                    // cycles 2..8
            step();
            chk("t7_wait_valid", per_valid, 1);
        end
        step(); per_ready = 1'b1; per_rdata = 32'hCAFE_F00D;       // cycle 9
        chk("t7_last_valid", per_valid, 1);
        step(); per_ready = 1'b0;                                  // cycle 10
        chk("t7_rsp_valid", rsp_valid, 1);
        chk("t7_rsp_err", rsp_err, 0);
        chk("t7_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        step();
        wait_idle("t7_idle");
`else
        // Without the timeout, a long stall is simply waited out
        per_ready = 1'b0;
        step(); offer(1'b0, 12'h3F0, 32'h0);
        step(); cmd_valid = 1'b0;
        for (int k = 0; k < 2 * TMO; k++) begin
            step();
            chk("t6_long_wait_valid", per_valid, 1);
        end
        per_ready = 1'b1;
        per_rdata = 32'hCAFE_F00D;
        step(); per_ready = 1'b0;
        chk("t6_rsp_valid", rsp_valid, 1);
        chk("t6_rsp_err", rsp_err, 0);
        chk("t6_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
        step();
        wait_idle("t6_idle");
`endif

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
